// File: rtl/rec_packer_pkg.sv
// Shared sorting-network helpers: lane count, padding sentinel and lane slicing.
package rec_packer_pkg;

    localparam int MAX_RECW = 1024;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } pack_state_e;

    function automatic int lanes(input int p_log);
        return 1 << p_log;
    endfunction

    // Padding record: key field all ones so it sorts above every real key.
    function automatic logic [MAX_RECW-1:0] sentinel_rec(input int keyw);
        logic [MAX_RECW-1:0] r;
        r = '0;
        for (int b = 0; b < keyw; b++) r[b] = 1'b1;
        return r;
    endfunction

    function automatic int lane_lo(input int lane, input int datw);
        return lane * datw;
    endfunction

endpackage

// File: rtl/rec_packer_if.sv
// Record-in / vector-out bundle between a record source, the packer and the sorting network.
interface rec_packer_if #(
    parameter int P_LOG = 4,
    parameter int DATW  = 64
);
    import rec_packer_pkg::*;

    logic [DATW-1:0]                   DIN;
    logic                              DINEN;
    logic                              DINRDY;
    logic                              FLUSH;
    logic [DATW*lanes(P_LOG)-1:0]      DOT;
    logic                              DOTEN;
    logic [P_LOG:0]                    DOTCNT;
    logic                              DOTLAST;

    modport master (
        output DIN, DINEN, FLUSH,
        input  DINRDY, DOT, DOTEN, DOTCNT, DOTLAST
    );

    modport slave (
        input  DIN, DINEN, FLUSH,
        output DINRDY, DOT, DOTEN, DOTCNT, DOTLAST
    );

endinterface

// File: rtl/rec_packer.sv
// Packs records into N-lane vectors for the sorting network; vector out 1 cycle after the closing accept.
// Never backpressures after the first post-reset cycle; FLUSH closes a partial vector padded with sentinels.
module rec_packer
    import rec_packer_pkg::*;
#(
    parameter int P_LOG = 4,
    parameter int DATW  = 64,
    parameter int KEYW  = 32
) (
    input  logic         CLK,
    input  logic         RST,
    rec_packer_if.slave  pif
);

    localparam int N  = lanes(P_LOG);
    localparam int CW = P_LOG + 1;
    localparam logic [DATW-1:0] SENTINEL = DATW'(sentinel_rec(KEYW));

    pack_state_e           state_q, state_d;
    logic [P_LOG-1:0]      cnt_q, cnt_d;
    logic [DATW-1:0]       lane_q [N];
    logic [DATW-1:0]       lane_d [N];
    logic [DATW*N-1:0]     dot_q, dot_d;
    logic                  doten_q, doten_d;
    logic [P_LOG:0]        dotcnt_q, dotcnt_d;
    logic                  dotlast_q, dotlast_d;
    logic                  rdy_q, rdy_d;

    logic                  acc;
    logic                  full;
    logic                  close;
    logic                  emit;
    logic [P_LOG:0]        count_now;

    always_comb begin
        acc       = pif.DINEN && rdy_q;
        count_now = {1'b0, cnt_q} + {{P_LOG{1'b0}}, acc};
        full      = acc && (cnt_q == P_LOG'(N - 1));
        close     = pif.FLUSH && ((state_q == ST_FILLING) || acc);
        emit      = full || close;

        state_d   = state_q;
        case (state_q)
            ST_EMPTY:   if (acc && !emit) state_d = ST_FILLING;
            ST_FILLING: if (emit)         state_d = ST_EMPTY;
            default:                      state_d = ST_EMPTY;
        endcase

        cnt_d     = emit ? '0 : count_now[P_LOG-1:0];
        rdy_d     = 1'b1;

        lane_d    = lane_q;
        if (acc) lane_d[cnt_q] = pif.DIN;

        // The closing record bypasses the lane buffer so it lands in DOT on the same edge.
        dot_d     = dot_q;
        doten_d   = emit;
        dotcnt_d  = emit ? count_now : '0;
        dotlast_d = close;
        if (emit) begin
            for (int i = 0; i < N; i++) begin
                if (acc && (cnt_q == P_LOG'(i)))
                    dot_d[lane_lo(i, DATW) +: DATW] = pif.DIN;
                else if (CW'(i) < count_now)
                    dot_d[lane_lo(i, DATW) +: DATW] = lane_q[i];
                else
                    dot_d[lane_lo(i, DATW) +: DATW] = SENTINEL;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_EMPTY;
            cnt_q     <= '0;
            dot_q     <= '0;
            doten_q   <= 1'b0;
            dotcnt_q  <= '0;
            dotlast_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dot_q     <= dot_d;
            doten_q   <= doten_d;
            dotcnt_q  <= dotcnt_d;
            dotlast_q <= dotlast_d;
            rdy_q     <= rdy_d;
        end
    end

    // Lane contents beyond cnt are don't-care, so the buffer needs no reset.
    always_ff @(posedge CLK) begin
        lane_q <= lane_d;
    end

    assign pif.DINRDY  = rdy_q;
    assign pif.DOT     = dot_q;
    assign pif.DOTEN   = doten_q;
    assign pif.DOTCNT  = dotcnt_q;
    assign pif.DOTLAST = dotlast_q;

endmodule

// File: tb/tb_rec_packer.sv
// Directed bench for rec_packer at P_LOG=2, DATW=16, KEYW=8.
module tb_rec_packer;

    localparam int P_LOG = 2;
    localparam int DATW  = 16;
    localparam int KEYW  = 8;

    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    rec_packer_if #(.P_LOG(P_LOG), .DATW(DATW)) pif ();

    rec_packer #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW)) dut (
        .CLK (CLK),
        .RST (RST),
        .pif (pif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic fl);
        pif.DIN   = d;
        pif.DINEN = 1'b1;
        pif.FLUSH = fl;
        tick();
    endtask

    task automatic idle(input logic fl);
        pif.DINEN = 1'b0;
        pif.FLUSH = fl;
        tick();
    endtask

    function automatic logic [15:0] rec34(input int k);
        return {8'(8'h50 + k), 8'(k * 7)};
    endfunction

    int            pulses;
    int            nrec;
    logic [63:0]   exp_vec;

    initial begin
        // Reset with DINEN held high.
        RST = 1'b1; pif.DIN = 16'hA005; pif.DINEN = 1'b1; pif.FLUSH = 1'b0;
        tick();
        chk("rst_rdy",     64'(pif.DINRDY),  64'd0);
        chk("rst_doten",   64'(pif.DOTEN),   64'd0);
        chk("rst_dotcnt",  64'(pif.DOTCNT),  64'd0);
        chk("rst_dotlast", 64'(pif.DOTLAST), 64'd0);
        chk("rst_dot",     pif.DOT,          64'd0);
        tick(); tick();
        chk("rst3_rdy",    64'(pif.DINRDY),  64'd0);

        RST = 1'b0;
        tick();
        chk("post_rst_rdy",   64'(pif.DINRDY), 64'd1);
        chk("post_rst_doten", 64'(pif.DOTEN),  64'd0);

        // Full vector: keys 05,01,09,03.
        send(16'hA005, 1'b0); chk("v1_a0_doten", 64'(pif.DOTEN), 64'd0);
        send(16'hA101, 1'b0); chk("v1_a1_doten", 64'(pif.DOTEN), 64'd0);
        send(16'hA209, 1'b0); chk("v1_a2_doten", 64'(pif.DOTEN), 64'd0);
        send(16'hA303, 1'b0);
        chk("v1_doten",   64'(pif.DOTEN),   64'd1);
        chk("v1_dotcnt",  64'(pif.DOTCNT),  64'd4);
        chk("v1_dotlast", 64'(pif.DOTLAST), 64'd0);
        chk("v1_dot",     pif.DOT,          64'hA303_A209_A101_A005);
        idle(1'b0);
        chk("v1_pulse_end", 64'(pif.DOTEN),  64'd0);
        chk("v1_cnt_clear", 64'(pif.DOTCNT), 64'd0);
        chk("v1_dot_hold",  pif.DOT,         64'hA303_A209_A101_A005);

        // Two records then FLUSH alone.
        send(16'hB011, 1'b0);
        send(16'hB122, 1'b0);
        idle(1'b1);
        chk("v2_doten",   64'(pif.DOTEN),   64'd1);
        chk("v2_dotcnt",  64'(pif.DOTCNT),  64'd2);
        chk("v2_dotlast", 64'(pif.DOTLAST), 64'd1);
        chk("v2_dot",     pif.DOT,          64'h00FF_00FF_B122_B011);
        idle(1'b0);
        chk("v2_last_end", 64'(pif.DOTLAST), 64'd0);
        chk("v2_pulse_end", 64'(pif.DOTEN),  64'd0);

        // Third record accepted together with FLUSH.
        send(16'hC033, 1'b0);
        send(16'hC144, 1'b0);
        send(16'hC255, 1'b1);
        chk("v3_doten",   64'(pif.DOTEN),   64'd1);
        chk("v3_dotcnt",  64'(pif.DOTCNT),  64'd3);
        chk("v3_dotlast", 64'(pif.DOTLAST), 64'd1);
        chk("v3_dot",     pif.DOT,          64'h00FF_C255_C144_C033);

        // Next record starts a new vector at lane 0; FLUSH on the lane-3 accept.
        send(16'hC366, 1'b0); chk("v4_a0_doten", 64'(pif.DOTEN), 64'd0);
        send(16'hC477, 1'b0);
        send(16'hC588, 1'b0);
        send(16'hC699, 1'b1);
        chk("v4_doten",   64'(pif.DOTEN),   64'd1);
        chk("v4_dotcnt",  64'(pif.DOTCNT),  64'd4);
        chk("v4_dotlast", 64'(pif.DOTLAST), 64'd1);
        chk("v4_dot",     pif.DOT,          64'hC699_C588_C477_C366);
        idle(1'b0);
        chk("v4_no_extra", 64'(pif.DOTEN), 64'd0);

        // FLUSH with nothing pending.
        idle(1'b1);
        chk("flush_empty_doten", 64'(pif.DOTEN), 64'd0);
        chk("flush_empty_dot",   pif.DOT,        64'hC699_C588_C477_C366);

        // Reset mid-vector, with DINEN and FLUSH also high on the reset edge.
        send(16'hE0E0, 1'b0);
        send(16'hE1E1, 1'b0);
        send(16'hE2E2, 1'b0);
        RST = 1'b1; pif.DIN = 16'hE3E3; pif.DINEN = 1'b1; pif.FLUSH = 1'b1;
        tick();
        chk("midrst_doten", 64'(pif.DOTEN),  64'd0);
        chk("midrst_rdy",   64'(pif.DINRDY), 64'd0);
        chk("midrst_dot",   pif.DOT,         64'd0);
        RST = 1'b0;
        idle(1'b0);
        chk("midrst_rdy_back", 64'(pif.DINRDY), 64'd1);
        send(16'hF000, 1'b0);
        send(16'hF101, 1'b0);
        send(16'hF202, 1'b0);
        send(16'hF303, 1'b0);
        chk("v5_doten",  64'(pif.DOTEN),  64'd1);
        chk("v5_dotcnt", 64'(pif.DOTCNT), 64'd4);
        chk("v5_dot",    pif.DOT,         64'hF303_F202_F101_F000);

        // 12 records with DINEN dropped every third cycle.
        pulses = 0;
        nrec   = 0;
        pif.FLUSH = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (c % 3 != 2) begin
                pif.DINEN = 1'b1;
                pif.DIN   = rec34(nrec);
                nrec++;
            end else begin
                pif.DINEN = 1'b0;
            end
            tick();
            if (pif.DOTEN === 1'b1) begin
                exp_vec = {rec34(4*pulses+3), rec34(4*pulses+2),
                           rec34(4*pulses+1), rec34(4*pulses)};
                chk($sformatf("gap_vec%0d_dot", pulses), pif.DOT, exp_vec);
                chk($sformatf("gap_vec%0d_at", pulses), 64'(nrec), 64'(4*pulses+4));
                pulses++;
            end
        end
        pif.DINEN = 1'b0;
        tick();
        chk("gap_pulses", 64'(pulses), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
